// File: rtl/fir_trig_disc.sv
// Trigger discriminator: turns NLANES filtered samples per clock into one trigger per pulse,
// with hysteresis, holdoff, first-crossing lane, time-over-threshold length and baseline pause.
module fir_trig_disc #(
    parameter int NLANES    = 4,
    parameter int FWIDTH    = 31,
    parameter int HOLD_W    = 8,
    parameter int TLEN_W    = 16,
    parameter int PAUSE_LEN = 8,
    localparam int LANE_W   = (NLANES > 1) ? $clog2(NLANES) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NLANES*FWIDTH-1:0] fin,
    input  logic                     fvalid_in,
    input  logic                     enable,
    input  logic signed [FWIDTH-1:0] thresh_hi,
    input  logic signed [FWIDTH-1:0] thresh_lo,
    input  logic [HOLD_W-1:0]        holdoff,
    output logic [NLANES-1:0]        tot_out,
    output logic                     trig_out,
    output logic [LANE_W-1:0]        trig_lane,
    output logic [TLEN_W-1:0]        tot_len,
    output logic                     tot_len_valid,
    output logic                     tot_trunc,
    output logic                     bsum_pause,
    output logic [1:0]               state_out
);

    localparam int PCNT_W = (PAUSE_LEN > 0) ? $clog2(PAUSE_LEN + 1) : 1;

    typedef enum logic [1:0] {
        ARMED   = 2'd0,
        ACTIVE  = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    function automatic logic [TLEN_W-1:0] sat_inc(input logic [TLEN_W-1:0] v);
        return (v == '1) ? v : v + TLEN_W'(1);
    endfunction

    state_t state, state_nxt;
    logic signed [FWIDTH-1:0] smp [NLANES];
    logic [NLANES-1:0]   over_hi;
    logic                all_lo;
    logic [LANE_W-1:0]   low_lane;
    logic [TLEN_W-1:0]   len, len_nxt, tlen_nxt;
    logic [HOLD_W-1:0]   hcnt, hcnt_nxt;
    logic [PCNT_W-1:0]   pcnt, pcnt_nxt;
    logic [LANE_W-1:0]   lane_nxt;
    logic                trig_nxt, exit_c, trunc_nxt, pause_nxt;

    for (genvar g = 0; g < NLANES; g++) begin : g_lane
        assign smp[g] = fin[FWIDTH*g +: FWIDTH];
    end

    // Raw signed comparators and lowest-lane priority encoder
    always_comb begin
        over_hi  = '0;
        all_lo   = fvalid_in;
        low_lane = '0;
        for (int i = 0; i < NLANES; i++) begin
            over_hi[i] = fvalid_in && (smp[i] > thresh_hi);
            if (!(smp[i] <= thresh_lo))
                all_lo = 1'b0;
        end
        for (int i = NLANES - 1; i >= 0; i--) begin
            if (over_hi[i])
                low_lane = LANE_W'(i);
        end
    end

    always_comb begin
        state_nxt = state;
        len_nxt   = len;
        hcnt_nxt  = hcnt;
        tlen_nxt  = tot_len;
        lane_nxt  = trig_lane;
        trunc_nxt = tot_trunc;
        trig_nxt  = 1'b0;
        exit_c    = 1'b0;
        pcnt_nxt  = pcnt;
        pause_nxt = 1'b0;
        case (state)
            ARMED: begin
                if (enable && (over_hi != '0)) begin
                    trig_nxt  = 1'b1;
                    lane_nxt  = low_lane;
                    len_nxt   = TLEN_W'(1);
                    state_nxt = ACTIVE;
                end
            end
            ACTIVE: begin
                // Truncation outranks the normal release so a dropped stream is flagged
                if (!enable || !fvalid_in) begin
                    exit_c    = 1'b1;
                    trunc_nxt = 1'b1;
                end else if (all_lo) begin
                    exit_c    = 1'b1;
                    trunc_nxt = 1'b0;
                end else begin
                    len_nxt = sat_inc(len);
                end
                if (exit_c) begin
                    tlen_nxt = len;
                    if (holdoff != '0) begin
                        state_nxt = HOLDOFF;
                        hcnt_nxt  = holdoff;
                    end else begin
                        state_nxt = ARMED;
                    end
                end
            end
            HOLDOFF: begin
                if (hcnt <= HOLD_W'(1)) begin
                    state_nxt = ARMED;
                    hcnt_nxt  = '0;
                end else begin
                    hcnt_nxt = hcnt - HOLD_W'(1);
                end
            end
            default: state_nxt = ARMED;
        endcase

        // Pause covers the pulse itself plus PAUSE_LEN cycles past the exit edge
        if (state_nxt == ACTIVE) begin
            pcnt_nxt  = '0;
            pause_nxt = 1'b1;
        end else if (exit_c) begin
            pcnt_nxt  = PCNT_W'(PAUSE_LEN);
            pause_nxt = 1'b1;
        end else if (pcnt != '0) begin
            pcnt_nxt  = pcnt - PCNT_W'(1);
            pause_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ARMED;
            len           <= '0;
            hcnt          <= '0;
            pcnt          <= '0;
            tot_out       <= '0;
            trig_out      <= 1'b0;
            trig_lane     <= '0;
            tot_len       <= '0;
            tot_len_valid <= 1'b0;
            tot_trunc     <= 1'b0;
            bsum_pause    <= 1'b0;
        end else begin
            state         <= state_nxt;
            len           <= len_nxt;
            hcnt          <= hcnt_nxt;
            pcnt          <= pcnt_nxt;
            tot_out       <= over_hi;
            trig_out      <= trig_nxt;
            trig_lane     <= lane_nxt;
            tot_len       <= tlen_nxt;
            tot_len_valid <= exit_c;
            tot_trunc     <= trunc_nxt;
            bsum_pause    <= pause_nxt;
        end
    end

    assign state_out = state;

endmodule

// File: tb/tb_fir_trig_disc.sv
// Directed table-driven bench for fir_trig_disc (NLANES=4, TLEN_W=4, PAUSE_LEN=8).
module tb_fir_trig_disc;

    localparam int NL = 4;
    localparam int FW = 31;

    logic              clk = 1'b0;
    logic              reset;
    logic [NL*FW-1:0]  fin;
    logic              fvalid_in, enable;
    logic signed [FW-1:0] thresh_hi, thresh_lo;
    logic [7:0]        holdoff;
    logic [NL-1:0]     tot_out;
    logic              trig_out;
    logic [1:0]        trig_lane;
    logic [3:0]        tot_len;
    logic              tot_len_valid, tot_trunc, bsum_pause;
    logic [1:0]        state_out;

    int n_chk  = 0;
    int n_fail = 0;

    fir_trig_disc #(.NLANES(NL), .FWIDTH(FW), .HOLD_W(8), .TLEN_W(4), .PAUSE_LEN(8)) dut (
        .clk(clk), .reset(reset), .fin(fin), .fvalid_in(fvalid_in), .enable(enable),
        .thresh_hi(thresh_hi), .thresh_lo(thresh_lo), .holdoff(holdoff),
        .tot_out(tot_out), .trig_out(trig_out), .trig_lane(trig_lane), .tot_len(tot_len),
        .tot_len_valid(tot_len_valid), .tot_trunc(tot_trunc), .bsum_pause(bsum_pause),
        .state_out(state_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic fv, en;
        int hi, lo, ho;
        int w0, w1, w2, w3;
        logic trig; int lane; logic [3:0] tot; logic tlv; int tlen; logic trunc, pause; int st;
    } vec_t;

    vec_t q[$];

    function automatic logic [15:0] pack(logic trig, logic [1:0] lane, logic [3:0] tot, logic tlv,
                                         logic [3:0] tlen, logic trunc, logic pause, logic [1:0] st);
        return {trig, lane, tot, tlv, tlen, trunc, pause, st};
    endfunction

    function automatic logic [15:0] act();
        return pack(trig_out, trig_lane, tot_out, tot_len_valid, tot_len, tot_trunc, bsum_pause, state_out);
    endfunction

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h {trig,lane,tot,tlv,tlen,trunc,pause,st}", name, got, exp);
        end
    endtask

    task automatic drive(input logic fv, input logic en, input int hi, input int lo, input int ho,
                         input int w0, input int w1, input int w2, input int w3);
        fvalid_in = fv;
        enable    = en;
        thresh_hi = FW'(hi);
        thresh_lo = FW'(lo);
        holdoff   = 8'(ho);
        fin       = {FW'(w3), FW'(w2), FW'(w1), FW'(w0)};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        drive(0, 0, 100, 20, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_held", act(), 16'h0000);
        #3 reset = 1'b0;
        step();
        chk("reset_idle", act(), 16'h0000);

        // Basic pulse, hysteresis words, pause extension, enable gating
        q.push_back('{1,1,100,20,0, 0,0,150,0,       1,2,4'b0100,0,0,0,1,1});
        q.push_back('{1,1,100,20,0, 50,50,50,50,     0,2,4'b0000,0,0,0,1,1});
        q.push_back('{1,1,100,20,0, 10,10,10,10,     0,2,4'b0000,1,2,0,1,0});
        q.push_back('{1,1,100,20,0, 30,30,30,30,     0,2,4'b0000,0,2,0,1,0});
        for (int i = 0; i < 7; i++)
            q.push_back('{0,1,100,20,0, 0,0,0,0,     0,2,4'b0000,0,2,0,1,0});
        q.push_back('{0,1,100,20,0, 0,0,0,0,         0,2,4'b0000,0,2,0,0,0});
        q.push_back('{1,0,100,20,0, 200,200,200,200, 0,2,4'b1111,0,2,0,0,0});
        // Holdoff 3: ignored words, re-trigger on 4th, holdoff latched at entry
        q.push_back('{1,1,100,20,3, 200,0,0,0,       1,0,4'b0001,0,2,0,1,1});
        q.push_back('{1,1,100,20,3, 10,10,10,10,     0,0,4'b0000,1,1,0,1,2});
        q.push_back('{1,1,100,20,3, 200,200,200,200, 0,0,4'b1111,0,1,0,1,2});
        q.push_back('{1,1,100,20,3, 200,200,200,200, 0,0,4'b1111,0,1,0,1,2});
        q.push_back('{1,1,100,20,3, 200,200,200,200, 0,0,4'b1111,0,1,0,1,0});
        q.push_back('{1,1,100,20,3, 200,200,200,200, 1,0,4'b1111,0,1,0,1,1});
        q.push_back('{0,1,100,20,3, 0,0,0,0,         0,0,4'b0000,1,1,1,1,2});
        q.push_back('{0,1,100,20,0, 0,0,0,0,         0,0,4'b0000,0,1,1,1,2});
        q.push_back('{0,1,100,20,0, 0,0,0,0,         0,0,4'b0000,0,1,1,1,2});
        q.push_back('{1,1,100,20,0, 200,200,200,200, 0,0,4'b1111,0,1,1,1,0});
        q.push_back('{1,1,100,20,0, 0,0,0,200,       1,3,4'b1000,0,1,1,1,1});
        q.push_back('{1,0,100,20,0, 200,200,200,200, 0,3,4'b1111,1,1,1,1,0});
        q.push_back('{1,1,100,20,0, 0,150,150,0,     1,1,4'b0110,0,1,1,1,1});
        q.push_back('{1,1,100,20,0, 10,10,10,10,     0,1,4'b0000,1,1,0,1,0});
        // Negative thresholds
        q.push_back('{1,1,-50,-100,0, -200,-40,-200,-200, 1,1,4'b0010,0,1,0,1,1});
        q.push_back('{1,1,-50,-100,0, -60,-60,-60,-60,    0,1,4'b0000,0,1,0,1,1});
        q.push_back('{1,1,-50,-100,0, -120,-120,-120,-120, 0,1,4'b0000,1,2,0,1,0});
        // thresh_lo above thresh_hi, then strict/inclusive comparator boundaries
        q.push_back('{1,1,100,150,0, 120,0,0,0,      1,0,4'b0001,0,2,0,1,1});
        q.push_back('{1,1,100,150,0, 140,140,140,140, 0,0,4'b1111,1,1,0,1,0});
        q.push_back('{1,1,100,20,0, 100,100,100,100, 0,0,4'b0000,0,1,0,1,0});
        q.push_back('{1,1,100,20,0, 101,0,0,0,       1,0,4'b0001,0,1,0,1,1});
        q.push_back('{1,1,100,20,0, 20,20,20,21,     0,0,4'b0000,0,1,0,1,1});
        q.push_back('{1,1,100,20,0, 20,20,20,20,     0,0,4'b0000,1,2,0,1,0});

        foreach (q[k]) begin
            drive(q[k].fv, q[k].en, q[k].hi, q[k].lo, q[k].ho, q[k].w0, q[k].w1, q[k].w2, q[k].w3);
            step();
            chk($sformatf("vec%0d", k), act(),
                pack(q[k].trig, 2'(q[k].lane), q[k].tot, q[k].tlv, 4'(q[k].tlen),
                     q[k].trunc, q[k].pause, 2'(q[k].st)));
        end

        // Saturation of a 20-word pulse at 15, then truncation by invalid input
        drive(1, 1, 100, 20, 0, 200, 200, 200, 200);
        step();
        chk("sat_trig", {trig_out, state_out}, {1'b1, 2'd1});
        for (int i = 0; i < 19; i++) step();
        chk("sat_active", {trig_out, tot_len_valid, state_out}, {1'b0, 1'b0, 2'd1});
        drive(0, 1, 100, 20, 0, 0, 0, 0, 0);
        step();
        chk("sat_exit", {tot_len_valid, tot_len, tot_trunc, state_out}, {1'b1, 4'd15, 1'b1, 2'd0});
        step();
        chk("tlv_one_cycle", {tot_len_valid, tot_len}, {1'b0, 4'd15});

        // Asynchronous reset in the middle of a pulse
        drive(1, 1, 100, 20, 0, 200, 200, 200, 200);
        step();
        chk("pre_reset_trig", {trig_out, state_out}, {1'b1, 2'd1});
        @(posedge clk);
        #3 reset = 1'b1;
        #1 chk("async_reset", act(), 16'h0000);
        #2 reset = 1'b0;
        drive(1, 1, 100, 20, 0, 0, 0, 200, 0);
        step();
        chk("post_reset_trig", act(), pack(1'b1, 2'd2, 4'b0100, 1'b0, 4'd0, 1'b0, 1'b1, 2'd1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fir_trig_disc.md
# fir_trig_disc

Parametrised trigger discriminator that takes NLANES filtered samples per clock and turns them into one trigger event per pulse. It adds hysteresis (separate arm/release thresholds), a programmable holdoff, a first-crossing lane index and a measured time-over-threshold length. It sits directly after the FIR filter stage and replaces the fixed four-lane raw-comparator TOT logic. Its bsum_pause output drives the baseline summer's pause input.

## Interface
- NLANES, 4, samples per clock (≥1)
- FWIDTH, 31, signed filtered-sample width
- HOLD_W, 8, holdoff counter width
- TLEN_W, 16, TOT length counter width
- PAUSE_LEN, 8, cycles bsum_pause is held after a pulse ends

Ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high reset
- fin  in  NLANES*FWIDTH  signed filtered samples; lane i = bits [FWIDTH*(i+1)-1 : FWIDTH*i]; lane 0 is earliest in time
- fvalid_in  in  1  fin word is valid
- enable  in  1  trigger enable
- thresh_hi  in  FWIDTH  signed arm threshold (strict >)
- thresh_lo  in  FWIDTH  signed release threshold (≤)
- holdoff  in  HOLD_W  re-arm holdoff in cycles
- tot_out  out  NLANES  per-lane raw comparator: fvalid_in && fin[i] > thresh_hi
- trig_out  out  1  one-cycle trigger pulse
- trig_lane  out  max(1,$clog2(NLANES))  lowest lane over thresh_hi in the trigger word
- tot_len  out  TLEN_W  pulse length in words, saturating
- tot_len_valid  out  1  one-cycle strobe; tot_len and tot_trunc are valid
- tot_trunc  out  1  pulse ended by invalid input or enable drop
- bsum_pause  out  1  pause request for the baseline summer
- state_out  out  2  0 ARMED, 1 ACTIVE, 2 HOLDOFF

## Operation
- Per lane: over_hi[i] = fvalid_in && fin[i] > thresh_hi. all_lo = fvalid_in && every fin[i] ≤ thresh_lo. Both comparisons are signed.
- ARMED:
  - If enable && any over_hi: raise trig_out, latch trig_lane = lowest such i, set len=1, go to ACTIVE.
  - Otherwise stay in ARMED.
- ACTIVE (evaluated in priority order):
  1. !enable or !fvalid_in: exit with tot_trunc=1.
  2. all_lo: exit with tot_trunc=0.
  3. Otherwise: len = min(len+1, 2^TLEN_W−1).
- On exit: pulse tot_len_valid, output tot_len = len. Go to HOLDOFF with hcnt = holdoff if holdoff ≠ 0, otherwise go to ARMED.
- HOLDOFF:
  - All words are ignored.
  - Each cycle, hcnt decrements. When hcnt == 1, go to ARMED.
  - enable low does not shorten holdoff.
- The word that causes an exit can never trigger.
- Changes to holdoff only take effect when HOLDOFF is entered. Thresholds are used live.
- thresh_lo ≥ thresh_hi is legal: a word is checked for the all_lo exit before it can extend the pulse.
- tot_out is independent of the state machine and is always the registered raw comparator.
- bsum_pause:
  - Is 1 while state is ACTIVE.
  - Stays 1 for PAUSE_LEN cycles after the exit edge, then drops to 0.
  - A new trigger during that extension keeps it at 1.
- Reset (asynchronous, any state):
  - state = ARMED.
  - All outputs 0: trig_out, trig_lane, tot_out, tot_len, tot_len_valid, tot_trunc, bsum_pause.
  - Counters cleared.

## Timing
- Every output is registered. Latency is 1 cycle: a word sampled at edge k is reflected in outputs after edge k.
- trig_out and tot_len_valid are high for exactly one cycle each.
- trig_lane and tot_len hold their values until the next trigger or exit, respectively.
- tot_len counts the trigger word plus each extending word. The ending word is not counted.
- With holdoff = H > 0 and exit at edge e:
  - Words at edges e+1 … e+H are ignored.
  - The word at edge e+H+1 may trigger.
- With H = 0, the word at edge e+1 may trigger.
- bsum_pause rises with trig_out and falls PAUSE_LEN+1 edges after the exit edge.

## Test plan
- NLANES=4, thresh_hi=100, thresh_lo=20, holdoff=0. Words: w0={0,0,150,0}, w1={50,50,50,50}, w2={10,10,10,10}. Required: trig_out after w0 with trig_lane=2; tot_out=4'b0100 after w0; after w2, tot_len_valid=1, tot_len=2, tot_trunc=0; bsum_pause high from w0 for 1+8 cycles past the exit.
- Same stimulus plus a word w3={30,30,30,30}. Required: w1 and w3 (both below thresh_hi, above thresh_lo) never trigger; exactly one trig_out.
- holdoff=3. After the exit, present over-threshold words every cycle. Required: no trig_out for 3 cycles; re-trigger on the 4th word; state_out goes 2 → 0 → 1.
- TLEN_W=4, 20 consecutive words at 200. Required: tot_len saturates at 15. Then drop fvalid_in. Required: tot_len_valid=1, tot_trunc=1, tot_len=15.
- Negative values: thresh_hi=−50, thresh_lo=−100, lane value −40. Required: triggers. Then lane value −120 on all lanes. Required: exits.
- Assert reset mid-ACTIVE, asynchronously between edges. Required: all outputs 0 and state_out=0 immediately; the first over-threshold word after release triggers.
